// File: rtl/mod_counter.sv
// Parametrised synchronous up/down modulo counter with parallel load,
// wrap/saturate mode, combinational terminal count and registered wrap pulse.
module mod_counter #(
    parameter int     WIDTH    = 3,
    parameter longint MODULUS  = longint'(1) << WIDTH,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Range compares are done in 64 bits so MODULUS = 2**WIDTH cannot overflow.
    localparam logic [63:0]      MOD64 = 64'(MODULUS);
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
            MODULUS > (longint'(1) << WIDTH)) begin : g_bad_params
            $fatal(1, "mod_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (64'(count) == (MOD64 - 64'd1));
    assign at_zero = (count == '0);
    assign tc      = up ? at_max : at_zero;

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = (64'(load_val) < MOD64) ? load_val : MAXV;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    wrap_next  = 1'b1;
                    count_next = SATURATE ? count : '0;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    wrap_next  = 1'b1;
                    count_next = SATURATE ? count : MAXV;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: four configurations driven from a
// vector table and a model-driven random run, checked through a scoreboard queue.
module tb_mod_counter;

    typedef struct {
        int         dut;
        logic       rst;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic [3:0] expCount;
        logic       expWrap;
        logic       expTc;
        string      name;
    } vec_t;

    typedef struct {
        int         dut;
        logic [3:0] expCount;
        logic       expWrap;
        logic       expTc;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstV  [4];
    logic       enV   [4];
    logic       upV   [4];
    logic       loadV [4];
    logic [3:0] lvV   [4];
    logic       wrapV [4];
    logic       tcV   [4];
    logic [2:0] c0, c1, c2;
    logic [3:0] c3;

    int testsRun = 0;
    int testsFailed = 0;
    vec_t vecs[$];
    exp_t sb[$];
    logic [3:0] modelCount [4];
    int modOf [4] = '{8, 6, 6, 16};
    bit satOf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    // d0: W3 M8 wrap, d1: W3 M6 wrap, d2: W3 M6 saturate, d3: W4 M16 wrap
    mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) d0 (
        .clk(clk), .rst(rstV[0]), .en(enV[0]), .up(upV[0]), .load(loadV[0]),
        .load_val(lvV[0][2:0]), .count(c0), .tc(tcV[0]), .wrap(wrapV[0]));
    mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) d1 (
        .clk(clk), .rst(rstV[1]), .en(enV[1]), .up(upV[1]), .load(loadV[1]),
        .load_val(lvV[1][2:0]), .count(c1), .tc(tcV[1]), .wrap(wrapV[1]));
    mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) d2 (
        .clk(clk), .rst(rstV[2]), .en(enV[2]), .up(upV[2]), .load(loadV[2]),
        .load_val(lvV[2][2:0]), .count(c2), .tc(tcV[2]), .wrap(wrapV[2]));
    mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) d3 (
        .clk(clk), .rst(rstV[3]), .en(enV[3]), .up(upV[3]), .load(loadV[3]),
        .load_val(lvV[3]), .count(c3), .tc(tcV[3]), .wrap(wrapV[3]));

    function automatic logic [3:0] getCount(input int d);
        case (d)
            0:       return {1'b0, c0};
            1:       return {1'b0, c1};
            2:       return {1'b0, c2};
            default: return c3;
        endcase
    endfunction

    task automatic addVec(input int d, input logic r, input logic ld, input logic e,
                          input logic u, input int lv, input int ec,
                          input logic ew, input logic et, input string nm);
        vec_t v;
        v.dut = d; v.rst = r; v.load = ld; v.en = e; v.up = u;
        v.lv = 4'(lv); v.expCount = 4'(ec); v.expWrap = ew; v.expTc = et;
        v.name = nm;
        vecs.push_back(v);
    endtask

    // Drives one DUT for one cycle (others idle) and queues what it must show afterwards.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            rstV[i] = 1'b0; enV[i] = 1'b0; loadV[i] = 1'b0;
        end
        rstV[v.dut] = v.rst; loadV[v.dut] = v.load; enV[v.dut] = v.en;
        upV[v.dut] = v.up; lvV[v.dut] = v.lv;
        e.dut = v.dut; e.expCount = v.expCount; e.expWrap = v.expWrap;
        e.expTc = v.expTc; e.name = v.name;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        logic [3:0] act;
        testsRun++;
        if (sb.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        act = getCount(e.dut);
        if (act !== e.expCount || wrapV[e.dut] !== e.expWrap || tcV[e.dut] !== e.expTc) begin
            testsFailed++;
            $display("[TB] FAIL %s (dut%0d): count=%0d wrap=%b tc=%b, required count=%0d wrap=%b tc=%b",
                     e.name, e.dut, act, wrapV[e.dut], tcV[e.dut],
                     e.expCount, e.expWrap, e.expTc);
        end
    endtask

    task automatic stepAndCheck(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Independent reference: one clock edge of the counter for dut d.
    task automatic modelStep(input int d, input vec_t v, output logic [3:0] nc,
                             output logic nw);
        int c = int'(modelCount[d]);
        int m = modOf[d];
        nw = 1'b0;
        if (v.rst) c = 0;
        else if (v.load) c = (int'(v.lv) < m) ? int'(v.lv) : m - 1;
        else if (v.en) begin
            if (v.up) begin
                if (c == m - 1) begin nw = 1'b1; if (!satOf[d]) c = 0; end
                else c = c + 1;
            end else begin
                if (c == 0) begin nw = 1'b1; if (!satOf[d]) c = m - 1; end
                else c = c - 1;
            end
        end
        nc = 4'(c);
    endtask

    initial begin
        vec_t v;
        exp_t e;
        logic [3:0] nc;
        logic nw;
        int lvMax;

        for (int i = 0; i < 4; i++) begin
            rstV[i] = 1'b1; enV[i] = 1'b1; upV[i] = 1'b0; loadV[i] = 1'b1; lvV[i] = 4'd3;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            e.dut = i; e.expCount = 4'd0; e.expWrap = 1'b0; e.expTc = 1'b1; e.name = "reset";
            sb.push_back(e);
        end
        for (int i = 0; i < 4; i++) checkOutput();

        // Idle after reset (M8)
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 1, "idle_down");
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 1, "idle_down");
        addVec(0, 0, 0, 0, 1, 0, 0, 0, 0, "idle_up");
        addVec(0, 0, 0, 0, 1, 0, 0, 0, 0, "idle_up");
        // Up wrap, M6
        addVec(1, 0, 0, 1, 1, 0, 1, 0, 0, "upwrap_1");
        addVec(1, 0, 0, 1, 1, 0, 2, 0, 0, "upwrap_2");
        addVec(1, 0, 0, 1, 1, 0, 3, 0, 0, "upwrap_3");
        addVec(1, 0, 0, 1, 1, 0, 4, 0, 0, "upwrap_4");
        addVec(1, 0, 0, 1, 1, 0, 5, 0, 1, "upwrap_5");
        addVec(1, 0, 0, 1, 1, 0, 0, 1, 0, "upwrap_0");
        addVec(1, 0, 0, 1, 1, 0, 1, 0, 0, "upwrap_1b");
        addVec(1, 0, 0, 1, 1, 0, 2, 0, 0, "upwrap_2b");
        // Load priority and clamp, M6
        addVec(1, 0, 1, 0, 1, 3, 3, 0, 0, "load_3");
        addVec(1, 0, 1, 1, 1, 7, 5, 0, 1, "load_clamp");
        addVec(1, 0, 0, 1, 1, 0, 0, 1, 0, "after_clamp_wrap");
        addVec(1, 0, 1, 1, 0, 4, 4, 0, 0, "load_at_range_end");
        addVec(1, 0, 0, 1, 1, 0, 5, 0, 1, "pre_rst_5");
        addVec(1, 0, 0, 1, 1, 0, 0, 1, 0, "pre_rst_wrap");
        addVec(1, 1, 0, 1, 1, 0, 0, 0, 0, "rst_clears_wrap");
        // Down with saturate, M6
        addVec(2, 0, 1, 0, 0, 2, 2, 0, 0, "sat_load_2");
        addVec(2, 0, 0, 1, 0, 0, 1, 0, 0, "sat_down_1");
        addVec(2, 0, 0, 1, 0, 0, 0, 0, 1, "sat_down_0");
        addVec(2, 0, 0, 1, 0, 0, 0, 1, 1, "sat_hold0_a");
        addVec(2, 0, 0, 1, 0, 0, 0, 1, 1, "sat_hold0_b");
        addVec(2, 0, 1, 0, 1, 5, 5, 0, 1, "sat_load_5");
        addVec(2, 0, 0, 1, 1, 0, 5, 1, 1, "sat_hold5");
        addVec(2, 0, 0, 0, 1, 0, 5, 0, 1, "sat_idle5");
        // Direction flip, reset mid-count and full range, M16
        addVec(3, 0, 1, 0, 1, 7, 7, 0, 0, "m16_load_7");
        addVec(3, 0, 0, 1, 1, 0, 8, 0, 0, "m16_up_8");
        addVec(3, 0, 0, 1, 1, 0, 9, 0, 0, "m16_up_9");
        addVec(3, 0, 0, 1, 0, 0, 8, 0, 0, "m16_flip_8");
        addVec(3, 1, 0, 1, 0, 0, 0, 0, 1, "m16_rst_mid");
        addVec(3, 0, 1, 0, 1, 15, 15, 0, 1, "m16_load_15");
        addVec(3, 0, 0, 1, 1, 0, 0, 1, 0, "m16_full_wrap_up");
        addVec(3, 0, 0, 1, 0, 0, 15, 1, 0, "m16_full_wrap_down");
        addVec(3, 0, 0, 1, 0, 0, 14, 0, 0, "m16_down_14");
        addVec(3, 0, 0, 0, 0, 0, 14, 0, 0, "m16_hold_14");

        foreach (vecs[i]) stepAndCheck(vecs[i]);

        // Random traffic on the M6 wrap, M6 saturate and M16 instances
        for (int d = 1; d < 4; d++) begin
            modelCount[d] = getCount(d) === 4'bx ? 4'd0 : 4'd0;
            v.dut = d; v.rst = 1'b1; v.load = 1'b0; v.en = 1'b0; v.up = 1'b1; v.lv = 4'd0;
            v.expCount = 4'd0; v.expWrap = 1'b0; v.expTc = 1'b0; v.name = "rand_reset";
            stepAndCheck(v);
            lvMax = (d == 3) ? 15 : 7;
            for (int k = 0; k < 30; k++) begin
                v.rst  = ($urandom_range(0, 19) == 0);
                v.load = ($urandom_range(0, 5) == 0);
                v.en   = ($urandom_range(0, 3) != 0);
                v.up   = 1'($urandom_range(0, 1));
                v.lv   = 4'($urandom_range(0, lvMax));
                modelStep(d, v, nc, nw);
                modelCount[d] = nc;
                v.expCount = nc;
                v.expWrap = nw;
                v.expTc = v.up ? (int'(nc) == modOf[d] - 1) : (nc == 4'd0);
                v.name = "random";
                stepAndCheck(v);
            end
        end

        if (sb.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
